decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 159 +++++++++++++++
 tb/tb_decode_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32 decode stage: ADD/SUB/SLT and ADDI/SLTI decode, register file, one-entry output hold.
// Optional macro DECODE_BYPASS_EN forwards same-cycle writeback data into operand reads.
module decode_stage #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_op,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [4:0]       out_rd,
  output logic             illegal
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [2:0] {
    OP_ZERO = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_LT   = 3'd3
  } alu_op_e;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  logic             out_valid_q, out_valid_d;
  alu_op_e          out_op_q, out_op_d;
  logic [WIDTH-1:0] out_x_q, out_x_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic [4:0]       out_rd_q, out_rd_d;
  logic             illegal_q, illegal_d;

  logic [6:0]       opcode, funct7;
  logic [2:0]       funct3;
  logic [4:0]       rs1, rs2, rd;
  logic [WIDTH-1:0] rs1_val, rs2_val, imm_val;
  logic             dec_legal;
  alu_op_e          dec_op;
  logic [WIDTH-1:0] dec_y;
  logic             accept;

  assign opcode  = in_instr[6:0];
  assign rd      = in_instr[11:7];
  assign funct3  = in_instr[14:12];
  assign rs1     = in_instr[19:15];
  assign rs2     = in_instr[24:20];
  assign funct7  = in_instr[31:25];
  assign imm_val = {{(WIDTH-12){in_instr[31]}}, in_instr[31:20]};

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Operand read; x0 and out-of-range indices read as zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && int'(rs1) < NREGS) rs1_val = regs_q[rs1[IW-1:0]];
    if (rs2 != 5'd0 && int'(rs2) < NREGS) rs2_val = regs_q[rs2[IW-1:0]];
`ifdef DECODE_BYPASS_EN
    if (wb_en && wb_rd == rs1 && rs1 != 5'd0) rs1_val = wb_data;
    if (wb_en && wb_rd == rs2 && rs2 != 5'd0) rs2_val = wb_data;
`else
`endif
  end

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = OP_ZERO;
    dec_y     = rs2_val;
    case (opcode)
      7'b0110011: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          dec_op    = OP_ADD;
        end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
          dec_legal = 1'b1;
          dec_op    = OP_SUB;
        end else if (funct3 == 3'b010 && funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          dec_op    = OP_LT;
        end
      end
      7'b0010011: begin
        dec_y = imm_val;
        if (funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_op    = OP_ADD;
        end else if (funct3 == 3'b010) begin
          dec_legal = 1'b1;
          dec_op    = OP_LT;
        end
      end
      default: ;
    endcase
  end

  // Output registers load only on a legal acceptance; an illegal word just pulses illegal.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    out_op_d    = out_op_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_rd_d    = out_rd_q;
    illegal_d   = accept && !dec_legal;
    if (accept && dec_legal) begin
      out_valid_d = 1'b1;
      out_op_d    = dec_op;
      out_x_d     = rs1_val;
      out_y_d     = dec_y;
      out_rd_d    = rd;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_en && wb_rd != 5'd0 && int'(wb_rd) < NREGS) regs_d[wb_rd[IW-1:0]] = wb_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_op_q    <= OP_ZERO;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_rd_q    <= '0;
      illegal_q   <= 1'b0;
      // NOTE: the register file is architecturally cleared by reset, so it is built from flops, not RAM.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_rd_q    <= out_rd_d;
      illegal_q   <= illegal_d;
      regs_q      <= regs_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_rd    = out_rd_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table plus hand-written handshake/reset sequences.
// Expectations follow DECODE_BYPASS_EN when it is defined for the build.
module tb_decode_stage;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             wb_en;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_op;
  logic [WIDTH-1:0] out_x;
  logic [WIDTH-1:0] out_y;
  logic [4:0]       out_rd;
  logic             illegal;

  decode_stage #(.WIDTH(WIDTH), .NREGS(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_rd    (out_rd),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        legal;
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  rd;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  localparam exp_t NONE = '0;

  exp_t sb[$];
  logic exp_ill;
  int   n_vec  = 0;
  int   n_fail = 0;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
    check("illegal", {31'd0, illegal}, {31'd0, exp_ill});
    if (sb.size() != 0) begin
      check("out_op", {29'd0, out_op}, {29'd0, sb[0].op});
      check("out_x", out_x, sb[0].x);
      check("out_y", out_y, sb[0].y);
      check("out_rd", {27'd0, out_rd}, {27'd0, sb[0].rd});
    end
  endtask

  // One clock: drive, check in_ready before the edge, update scoreboard, check outputs after.
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic ordy,
                     input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                     input exp_t e);
    logic exp_rdy;
    in_valid  = iv;
    in_instr  = ins;
    out_ready = ordy;
    wb_en     = we;
    wb_rd     = wrd;
    wb_data   = wd;
    #1;
    exp_rdy = (sb.size() == 0) || ordy;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    if (sb.size() != 0 && ordy) void'(sb.pop_front());
    exp_ill = iv && exp_rdy && !e.legal;
    if (iv && exp_rdy && e.legal) sb.push_back(e);
    #1;
    check_outputs();
  endtask

  // One reset cycle with in_valid and wb_en deliberately asserted; both must be ignored.
  task automatic reset_cycle();
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h002081B3;
    out_ready = 1'b0;
    wb_en     = 1'b1;
    wb_rd     = 5'd1;
    wb_data   = 32'd99;
    @(posedge clk);
    #1;
    sb.delete();
    exp_ill = 1'b0;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst illegal", {31'd0, illegal}, 32'd0);
    check("rst out_op", {29'd0, out_op}, 32'd0);
    check("rst out_x", out_x, 32'd0);
    check("rst out_y", out_y, 32'd0);
    check("rst out_rd", {27'd0, out_rd}, 32'd0);
    reset_n = 1'b1;
  endtask

  function automatic exp_t mk(input logic [2:0] op, input logic [31:0] x,
                              input logic [31:0] y, input logic [4:0] rd);
    return '{legal: 1'b1, op: op, x: x, y: y, rd: rd};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] byp_x;
    exp_ill = 1'b0;
    reset_cycle();
    reset_cycle();

    // Load R1=5, R2=7, R5=-3, R6=100.
    cyc(0, 32'h0, 1, 1, 5'd1, 32'd5, NONE);
    cyc(0, 32'h0, 1, 1, 5'd2, 32'd7, NONE);
    cyc(0, 32'h0, 1, 1, 5'd5, 32'hFFFF_FFFD, NONE);
    cyc(0, 32'h0, 1, 1, 5'd6, 32'd100, NONE);

    tbl[0]  = '{32'h002081B3, mk(3'd1, 32'd5, 32'd7, 5'd3)};                 // add  x3,x1,x2
    tbl[1]  = '{32'h402081B3, mk(3'd2, 32'd5, 32'd7, 5'd3)};                 // sub  x3,x1,x2
    tbl[2]  = '{32'h0020A2B3, mk(3'd3, 32'd5, 32'd7, 5'd5)};                 // slt  x5,x1,x2
    tbl[3]  = '{32'hFFF08213, mk(3'd1, 32'd5, 32'hFFFF_FFFF, 5'd4)};         // addi x4,x1,-1
    tbl[4]  = '{32'h0642A393, mk(3'd3, 32'hFFFF_FFFD, 32'd100, 5'd7)};       // slti x7,x5,100
    tbl[5]  = '{32'h022081B3, NONE};                                         // bad funct7
    tbl[6]  = '{32'h00600433, mk(3'd1, 32'd0, 32'd100, 5'd8)};               // add  x8,x0,x6
    tbl[7]  = '{32'h80030493, mk(3'd1, 32'd100, 32'hFFFF_F800, 5'd9)};       // addi x9,x6,-2048
    tbl[8]  = '{32'h4020A2B3, NONE};                                         // funct3 010 + funct7 0100000
    tbl[9]  = '{32'h00109093, NONE};                                         // slli
    tbl[10] = '{32'h00002083, NONE};                                         // load opcode
    tbl[11] = '{32'h0020A2B3, mk(3'd3, 32'd5, 32'd7, 5'd5)};                 // slt  x5,x1,x2

    foreach (tbl[i]) cyc(1, tbl[i].instr, 1, 0, 5'd0, 32'd0, tbl[i].e);
    cyc(0, 32'h0, 1, 0, 5'd0, 32'd0, NONE);

    // Back-pressure: held add stays stable 3 cycles; a write meanwhile must not touch it.
    cyc(1, 32'h002081B3, 1, 0, 5'd0, 32'd0, mk(3'd1, 32'd5, 32'd7, 5'd3));
    cyc(1, 32'h402081B3, 0, 1, 5'd1, 32'd50, mk(3'd2, 32'd50, 32'd7, 5'd3));
    cyc(1, 32'h402081B3, 0, 0, 5'd0, 32'd0,  mk(3'd2, 32'd50, 32'd7, 5'd3));
    cyc(1, 32'h402081B3, 0, 0, 5'd0, 32'd0,  mk(3'd2, 32'd50, 32'd7, 5'd3));
    cyc(1, 32'h402081B3, 1, 0, 5'd0, 32'd0,  mk(3'd2, 32'd50, 32'd7, 5'd3));
    cyc(0, 32'h0, 1, 0, 5'd0, 32'd0, NONE);
    cyc(0, 32'h0, 1, 0, 5'd0, 32'd0, NONE);

    // Illegal all-zero word: one-cycle pulse, no output.
    cyc(1, 32'h00000000, 1, 0, 5'd0, 32'd0, NONE);
    cyc(0, 32'h0, 1, 0, 5'd0, 32'd0, NONE);
    cyc(0, 32'h0, 1, 0, 5'd0, 32'd0, NONE);

    // Same-cycle writeback to R1 during acceptance.
`ifdef DECODE_BYPASS_EN
    byp_x = 32'd9;
`else
    byp_x = 32'd50;
`endif
    cyc(1, 32'h002081B3, 1, 1, 5'd1, 32'd9, mk(3'd1, byp_x, 32'd7, 5'd3));
    // R1 now 9 either way; write to x0 in the acceptance cycle must not leak.
    cyc(1, 32'h002081B3, 1, 0, 5'd0, 32'd0, mk(3'd1, 32'd9, 32'd7, 5'd3));
    cyc(1, 32'h002001B3, 1, 1, 5'd0, 32'd77, mk(3'd1, 32'd0, 32'd7, 5'd3));
    cyc(0, 32'h0, 1, 0, 5'd0, 32'd0, NONE);

    // Reset while an operation is held clears outputs and the register file.
    cyc(1, 32'h002081B3, 0, 0, 5'd0, 32'd0, mk(3'd1, 32'd9, 32'd7, 5'd3));
    cyc(0, 32'h0, 0, 0, 5'd0, 32'd0, NONE);
    reset_cycle();
    cyc(1, 32'h002081B3, 1, 0, 5'd0, 32'd0, mk(3'd1, 32'd0, 32'd0, 5'd3));
    cyc(0, 32'h0, 1, 0, 5'd0, 32'd0, NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
